uart_rx_cfg: RTL and testbench

Parametrised UART receiver; successor to the fixed 8N1 receiver. Adds configurable data width, parity, and one or two stop bits. Each bit is decided by a 3-sample majority vote, and false start bits are rejected. Output uses a valid/ready register with overrun, framing, parity and break reporting. Sits between the rxd pad (via its own internal 2-flop synchronizer) and a byte-stream consumer (loopback TX, FIFO or command parser).

---
 rtl/uart_rx_cfg.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5..9 data bits, none/odd/even parity, 1 or 2 stop bits)
//   clk          system clock
//   rst          synchronous reset, active-high
//   rxd          asynchronous serial line, idle high
//   rdata        received word, LSB = first bit on the line
//   rdata_valid  rdata and flags held valid until accepted
//   rdata_ready  consumer accepts the word when valid && ready
//   perr         parity error for the held word
//   ferr         a stop bit was sampled low for the held word
//   brk          every bit of the held frame was sampled low
//   overrun      one-cycle pulse: a completed frame was dropped because the output was full
module uart_rx_cfg #(
   parameter int CLK_PER_BIT = 10416,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rdata,
   output logic                 rdata_valid,
   input  logic                 rdata_ready,
   output logic                 perr,
   output logic                 ferr,
   output logic                 brk,
   output logic                 overrun
);
   localparam int H  = CLK_PER_BIT / 2;
   localparam int CW = $clog2(CLK_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT} state_t;
   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 sync1_q, sync1_d, sync2_q, sync2_d;
   logic                 s0_q, s0_d, s1_q, s1_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic                 par_q, par_d, perr_i_q, perr_i_d, ferr_i_q, ferr_i_d, brk_i_q, brk_i_d;
   logic [DATA_BITS-1:0] rdata_q, rdata_d;
   logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
   logic                 overrun_q, overrun_d;
   logic                 xd, wrap, dec, maj, commit, load;
   always_comb begin
      sync1_d  = rxd;
      sync2_d  = sync1_q;
      xd       = sync2_q;
      wrap     = cnt_q == CW'(CLK_PER_BIT - 1);
      dec      = cnt_q == CW'(H + 1);
      // two stored samples plus the live line form the 3-way vote at H+1
      maj      = (s0_q & s1_q) | (s0_q & xd) | (s1_q & xd);
      s0_d     = (cnt_q == CW'(H - 1)) ? xd : s0_q;
      s1_d     = (cnt_q == CW'(H)) ? xd : s1_q;
      cnt_d    = wrap ? '0 : cnt_q + 1'b1;
      state_d  = state_q;
      idx_d    = idx_q;
      sh_d     = sh_q;
      par_d    = par_q;
      perr_i_d = perr_i_q;
      ferr_i_d = ferr_i_q;
      brk_i_d  = brk_i_q;
      commit   = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!xd) begin
               state_d  = S_START;
               idx_d    = '0;
               par_d    = 1'b0;
               perr_i_d = 1'b0;
               ferr_i_d = 1'b0;
               brk_i_d  = 1'b1;
            end
         end
         S_START: begin
            if (dec && maj) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (wrap) state_d = S_DATA;
         end
         S_DATA: begin
            if (dec) begin
               sh_d    = {maj, sh_q[DATA_BITS-1:1]};
               par_d   = par_q ^ maj;
               brk_i_d = brk_i_q & ~maj;
            end
            if (wrap) begin
               idx_d = (idx_q == IW'(DATA_BITS - 1)) ? '0 : idx_q + 1'b1;
               if (idx_q == IW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end
         end
         S_PAR: begin
            if (dec) begin
               perr_i_d = (PARITY == 1) ? ~(par_q ^ maj) : (par_q ^ maj);
               brk_i_d  = brk_i_q & ~maj;
            end
            if (wrap) state_d = S_STOP;
         end
         S_STOP: begin
            if (dec) begin
               ferr_i_d = ferr_i_q | ~maj;
               brk_i_d  = brk_i_q & ~maj;
               // commit at the last stop mid-bit so a following start edge is not missed
               if (idx_q == IW'(STOP_BITS - 1)) begin
                  commit  = 1'b1;
                  cnt_d   = '0;
                  state_d = (brk_i_q & ~maj) ? S_WAIT : S_IDLE;
               end
            end
            if (wrap) idx_d = idx_q + 1'b1;
         end
         S_WAIT: begin
            cnt_d = '0;
            if (xd) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      load      = commit & (~valid_q | rdata_ready);
      rdata_d   = load ? sh_q : rdata_q;
      perr_d    = load ? perr_i_q : perr_q;
      ferr_d    = load ? (ferr_i_q | ~maj) : ferr_q;
      brk_d     = load ? (brk_i_q & ~maj) : brk_q;
      valid_d   = load | (valid_q & ~rdata_ready);
      overrun_d = commit & ~load;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         s0_q      <= 1'b1;
         s1_q      <= 1'b1;
         sh_q      <= '0;
         par_q     <= 1'b0;
         perr_i_q  <= 1'b0;
         ferr_i_q  <= 1'b0;
         brk_i_q   <= 1'b0;
         rdata_q   <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         brk_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         s0_q      <= s0_d;
         s1_q      <= s1_d;
         sh_q      <= sh_d;
         par_q     <= par_d;
         perr_i_q  <= perr_i_d;
         ferr_i_q  <= ferr_i_d;
         brk_i_q   <= brk_i_d;
         rdata_q   <= rdata_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         brk_q     <= brk_d;
         overrun_q <= overrun_d;
      end
   end
   assign rdata       = rdata_q;
   assign rdata_valid = valid_q;
   assign perr        = perr_q;
   assign ferr        = ferr_q;
   assign brk         = brk_q;
   assign overrun     = overrun_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench driving 8N1, 8E1, 8O1 and 7N2 receivers
module tb_uart_rx_cfg;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] rxd = '1;
   logic [3:0] rdy = '1;
   logic [3:0] v, pe, fe, bk, ov;
   logic [3:0] pv = '0;
   logic [7:0] rd0, rd1, rd2;
   logic [6:0] rd3;
   int checks = 0, failures = 0, cyc = 0, base;
   int st_cyc[4], rise_cyc[4], ov_cnt[4];
   logic [11:0] q[4][$];
   always #5 clk = ~clk;
   uart_rx_cfg #(.CLK_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst(rst), .rxd(rxd[0]), .rdata(rd0), .rdata_valid(v[0]), .rdata_ready(rdy[0]),
      .perr(pe[0]), .ferr(fe[0]), .brk(bk[0]), .overrun(ov[0]));
   uart_rx_cfg #(.CLK_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
      .clk(clk), .rst(rst), .rxd(rxd[1]), .rdata(rd1), .rdata_valid(v[1]), .rdata_ready(rdy[1]),
      .perr(pe[1]), .ferr(fe[1]), .brk(bk[1]), .overrun(ov[1]));
   uart_rx_cfg #(.CLK_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
      .clk(clk), .rst(rst), .rxd(rxd[2]), .rdata(rd2), .rdata_valid(v[2]), .rdata_ready(rdy[2]),
      .perr(pe[2]), .ferr(fe[2]), .brk(bk[2]), .overrun(ov[2]));
   uart_rx_cfg #(.CLK_PER_BIT(16), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
      .clk(clk), .rst(rst), .rxd(rxd[3]), .rdata(rd3), .rdata_valid(v[3]), .rdata_ready(rdy[3]),
      .perr(pe[3]), .ferr(fe[3]), .brk(bk[3]), .overrun(ov[3]));
   task automatic chk(input string n, input int u, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s u%0d got=%h required=%h at cycle %0d", n, u, got, exp, cyc);
      end
   endtask
   task automatic mon(input int u, input logic [8:0] d, input logic p, input logic f, input logic b);
      logic [11:0] e;
      if (q[u].size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_word u%0d got=%h required=none at cycle %0d", u, {d, p, f, b}, cyc);
      end else begin
         e = q[u].pop_front();
         chk("word{data,perr,ferr,brk}", u, {4'h0, d, p, f, b}, {4'h0, e});
      end
   endtask
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      pv <= v;
      for (int i = 0; i < 4; i++) begin
         if (!rst && v[i] && !pv[i]) rise_cyc[i] <= cyc;
         if (!rst && ov[i]) ov_cnt[i] <= ov_cnt[i] + 1;
      end
      if (!rst) begin
         if (v[0] && rdy[0]) mon(0, {1'b0, rd0}, pe[0], fe[0], bk[0]);
         if (v[1] && rdy[1]) mon(1, {1'b0, rd1}, pe[1], fe[1], bk[1]);
         if (v[2] && rdy[2]) mon(2, {1'b0, rd2}, pe[2], fe[2], bk[2]);
         if (v[3] && rdy[3]) mon(3, {2'b0, rd3}, pe[3], fe[3], bk[3]);
      end
   end
   function automatic logic [15:0] fr(input logic [8:0] d, input int nd, input int pb, input logic s1, input logic s2);
      logic [15:0] f;
      int k;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < nd; i++) f[1+i] = d[i];
      k = 1 + nd;
      if (pb >= 0) begin
         f[k] = pb[0];
         k++;
      end
      f[k] = s1;
      f[k+1] = s2;
      return f;
   endfunction
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic send(input int u, input logic [15:0] f, input int n);
      st_cyc[u] = cyc;
      for (int i = 0; i < n; i++) begin
         rxd[u] = f[i];
         idle(16);
      end
      rxd[u] = 1'b1;
   endtask
   task automatic push(input int u, input logic [8:0] d, input logic p, input logic f, input logic b);
      q[u].push_back({d, p, f, b});
   endtask
   task automatic chk_reset();
      chk("rst_valid", 0, {12'h0, v}, 16'h0);
      chk("rst_rdata0", 0, {8'h0, rd0}, 16'h0);
      chk("rst_rdata3", 3, {9'h0, rd3}, 16'h0);
      chk("rst_flags", 0, {pe, fe, bk, ov}, 16'h0);
   endtask
   initial begin
      for (int i = 0; i < 4; i++) begin
         ov_cnt[i] = 0;
         rise_cyc[i] = 0;
         st_cyc[i] = 0;
      end
      idle(3);
      chk_reset();
      rst = 1'b0;
      idle(4);
      // 8N1 0xA5; valid rises 2 sync + 1 idle-detect + 9 bits + (H+1) + 1 cycles after the start edge
      push(0, 9'h0A5, 0, 0, 0);
      send(0, fr(9'h0A5, 8, -1, 1, 1), 10);
      idle(20);
      chk("latency", 0, 16'(rise_cyc[0] - st_cyc[0]), 16'(16 * 9 + 8 + 5));
      // even parity (u1) and odd parity (u2)
      push(1, 9'h003, 1, 0, 0); send(1, fr(9'h003, 8, 1, 1, 1), 11); idle(20);
      push(1, 9'h003, 0, 0, 0); send(1, fr(9'h003, 8, 0, 1, 1), 11); idle(20);
      push(1, 9'h007, 0, 0, 0); send(1, fr(9'h007, 8, 1, 1, 1), 11); idle(20);
      push(2, 9'h003, 1, 0, 0); send(2, fr(9'h003, 8, 0, 1, 1), 11); idle(20);
      push(2, 9'h003, 0, 0, 0); send(2, fr(9'h003, 8, 1, 1, 1), 11); idle(20);
      // 7N2: clean frame, second stop low, then a short glitch followed by a clean frame
      push(3, 9'h055, 0, 0, 0); send(3, fr(9'h055, 7, -1, 1, 1), 10); idle(20);
      push(3, 9'h03C, 0, 1, 0); send(3, fr(9'h03C, 7, -1, 1, 0), 10); idle(20);
      rxd[3] = 1'b0; idle(5); rxd[3] = 1'b1; idle(40);
      push(3, 9'h02B, 0, 0, 0); send(3, fr(9'h02B, 7, -1, 1, 1), 10); idle(20);
      // overrun: second back-to-back frame is dropped while the first is held
      base = ov_cnt[0];
      rdy[0] = 1'b0;
      push(0, 9'h011, 0, 0, 0);
      send(0, fr(9'h011, 8, -1, 1, 1), 10);
      send(0, fr(9'h022, 8, -1, 1, 1), 10);
      idle(20);
      chk("overrun_cycles", 0, 16'(ov_cnt[0] - base), 16'd1);
      chk("held_valid", 0, {15'h0, v[0]}, 16'd1);
      chk("held_rdata", 0, {8'h0, rd0}, 16'h0011);
      rdy[0] = 1'b1;
      idle(3);
      chk("valid_drop", 0, {15'h0, v[0]}, 16'd0);
      // break: line low for 3 frame times
      push(0, 9'h000, 0, 1, 1);
      rxd[0] = 1'b0; idle(480); rxd[0] = 1'b1; idle(40);
      push(0, 9'h05A, 0, 0, 0); send(0, fr(9'h05A, 8, -1, 1, 1), 10); idle(20);
      // reset in the middle of a frame while a word is held
      rdy[0] = 1'b0;
      push(0, 9'h081, 0, 0, 0); send(0, fr(9'h081, 8, -1, 1, 1), 10); idle(20);
      chk("pre_rst_valid", 0, {15'h0, v[0]}, 16'd1);
      send(0, fr(9'h000, 8, -1, 1, 1), 4);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk_reset();
      for (int i = 0; i < 4; i++) q[i].delete();
      rdy[0] = 1'b1;
      idle(200);
      push(0, 9'h0C3, 0, 0, 0); send(0, fr(9'h0C3, 8, -1, 1, 1), 10); idle(20);
      for (int i = 0; i < 4; i++) chk("missing_words", i, 16'(q[i].size()), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
